// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcode, state and control-field encodings for the multicycle MIPS control FSM
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - combinational state-to-control mapping; MC_MEM_WAIT_EN gates IRWrite/PCWrite on mem_ready
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       active,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] AluOP,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNot
);

  logic fetch_done;
`ifdef MC_MEM_WAIT_EN
  assign fetch_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign fetch_done = 1'b1;
`endif

  always_comb begin
    IorD = 1'b0;  MemRead = 1'b0;  MemWrite = 1'b0;  IRWrite = 1'b0;
    MemtoReg = 1'b0;  RegDst = 1'b0;  RegWrite = 1'b0;  ALUSrcA = 1'b0;
    ALUSrcB = SRCB_RT;  AluOP = ALU_ADD;  PCSource = PCSRC_ALU;
    PCWrite = 1'b0;  PCWriteCond = 1'b0;  PCWriteCondNot = 1'b0;
    // inactive covers reset and the settling cycle right after it
    if (active) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;  ALUSrcB = SRCB_FOUR;
          IRWrite = fetch_done;  PCWrite = fetch_done;
        end
        S_DECODE: ALUSrcB = SRCB_IMM_SH;
        S_MEMADR, S_ADDIEX: begin ALUSrcA = 1'b1;  ALUSrcB = SRCB_IMM; end
        S_MEMRD:  begin MemRead = 1'b1;  IorD = 1'b1; end
        S_MEMWB:  begin RegWrite = 1'b1;  MemtoReg = 1'b1; end
        S_MEMWR:  begin MemWrite = 1'b1;  IorD = 1'b1; end
        S_EXEC:   begin ALUSrcA = 1'b1;  AluOP = ALU_FUNCT; end
        S_RWB:    begin RegWrite = 1'b1;  RegDst = 1'b1; end
        S_BEQ:    begin ALUSrcA = 1'b1;  AluOP = ALU_SUB;  PCSource = PCSRC_ALUOUT;  PCWriteCond = 1'b1; end
        S_BNE:    begin ALUSrcA = 1'b1;  AluOP = ALU_SUB;  PCSource = PCSRC_ALUOUT;  PCWriteCondNot = 1'b1; end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP:   begin PCSource = PCSRC_JUMP;  PCWrite = 1'b1; end
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM; define MC_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] AluOP,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNot,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_q, state_next;
  logic       running;
  logic       is_store;
  logic       mem_go;

`ifdef MC_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  // lw/sw choice is captured in DECODE so later opcode changes cannot steer MEMADR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      running  <= 1'b0;
      is_store <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE) is_store <= (opcode == OP_SW);
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_q)
      S_FETCH:  state_next = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BEQ;
          OP_BNE:       state_next = S_BNE;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = mem_go ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_RWB;
      S_ADDIEX: state_next = S_ADDIWB;
      default:  state_next = S_FETCH;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = running && (state_q == S_DECODE) && !is_supported_op(opcode);

  mc_output_decode u_decode (
    .state          (state_q),
    .active         (running),
    .mem_ready      (mem_ready),
    .IorD           (IorD),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .IRWrite        (IRWrite),
    .MemtoReg       (MemtoReg),
    .RegDst         (RegDst),
    .RegWrite       (RegWrite),
    .ALUSrcA        (ALUSrcA),
    .ALUSrcB        (ALUSrcB),
    .AluOP          (AluOP),
    .PCSource       (PCSource),
    .PCWrite        (PCWrite),
    .PCWriteCond    (PCWriteCond),
    .PCWriteCondNot (PCWriteCondNot)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized and directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, AluOP, PCSource;
  logic       PCWrite, PCWriteCond, PCWriteCondNot, illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .AluOP(AluOP), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCWriteCondNot(PCWriteCondNot),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: remaining state path of the current instruction
  int m_state;
  bit m_started;
  int m_path[$];

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
  endfunction

  function automatic void plan(input logic [5:0] op);
    m_path.delete();
    case (op)
      6'b100011: m_path = '{2, 3, 4};
      6'b101011: m_path = '{2, 5};
      6'b000000: m_path = '{6, 7};
      6'b000100: m_path = '{8};
      6'b000101: m_path = '{9};
      6'b001000: m_path = '{10, 11};
      6'b000010: m_path = '{12};
      default:   ;
    endcase
  endfunction

  function automatic void model_edge(input logic [5:0] op, input bit mr);
    if (!m_started) m_started = 1'b1;
    else if (WAIT_EN && !mr && (m_state == 0 || m_state == 3 || m_state == 5)) ;
    else if (m_state == 0) m_state = 1;
    else begin
      if (m_state == 1) plan(op);
      m_state = (m_path.size() > 0) ? m_path.pop_front() : 0;
    end
  endfunction

  // {IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,AluOP,PCSource,PCWrite,PCWriteCond,PCWriteCondNot}
  function automatic logic [16:0] exp_ctrl(input int s, input bit mr);
    bit iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, srca = 0;
    bit pcw = 0, pcc = 0, pcn = 0;
    logic [1:0] srcb = 2'd0, aop = 2'd0, pcs = 2'd0;
    if (m_started) begin
      case (s)
        0:  begin mrd = 1; srcb = 2'd1; irw = WAIT_EN ? mr : 1'b1; pcw = irw; end
        1:  srcb = 2'd3;
        2, 10: begin srca = 1; srcb = 2'd2; end
        3:  begin mrd = 1; iord = 1; end
        4:  begin rw = 1; m2r = 1; end
        5:  begin mwr = 1; iord = 1; end
        6:  begin srca = 1; aop = 2'd2; end
        7:  begin rw = 1; rdst = 1; end
        8:  begin srca = 1; aop = 2'd1; pcs = 2'd1; pcc = 1; end
        9:  begin srca = 1; aop = 2'd1; pcs = 2'd1; pcn = 1; end
        11: rw = 1;
        12: begin pcs = 2'd2; pcw = 1; end
        default: ;
      endcase
    end
    return {iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, pcw, pcc, pcn};
  endfunction

  logic [16:0] dut_ctrl;
  assign dut_ctrl = {IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                     ALUSrcB, AluOP, PCSource, PCWrite, PCWriteCond, PCWriteCondNot};

  task automatic check_all();
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("ctrl", 32'(dut_ctrl), 32'(exp_ctrl(m_state, mem_ready)));
    check_eq("illegal_op", 32'(illegal_op), 32'(m_started && m_state == 1 && !legal(opcode)));
  endtask

  task automatic step(input logic [5:0] op, input bit mr);
    opcode = op;
    mem_ready = mr;
    model_edge(op, mr);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_state = 0; m_started = 1'b0; m_path.delete();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    #1;
    check_all();
  endtask

  task automatic run_instr(input logic [5:0] op, input int exp_len);
    int n = 0;
    int ill = 0;
    bit saw_rw = 0, saw_mw = 0;
    for (int i = 0; i < 20 && !(m_started && m_state == 0); i++) step(6'h3f, 1'b1);
    do begin
      step(op, 1'b1);
      n++;
      if (illegal_op) ill++;
      if (RegWrite) saw_rw = 1;
      if (MemWrite) saw_mw = 1;
    end while (state != 4'd0 && n < 20);
    check_eq($sformatf("len_%b", op), 32'(n), 32'(exp_len));
    check_eq($sformatf("illegal_cycles_%b", op), 32'(ill), legal(op) ? 32'd0 : 32'd1);
    if (!legal(op)) begin
      check_eq("illegal_no_regwrite", 32'(saw_rw), 32'd0);
      check_eq("illegal_no_memwrite", 32'(saw_mw), 32'd0);
    end
  endtask

  localparam logic [5:0] OPS[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                   6'b000101, 6'b001000, 6'b000010, 6'b111111};

  initial begin
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b1;
    m_state = 0; m_started = 1'b0;
    @(negedge clk);
    check_all();
    reset = 1'b0;
    #1;
    check_all();
    step(6'b100011, 1'b1);

    run_instr(6'b100011, 5);
    run_instr(6'b101011, 4);
    run_instr(6'b000000, 4);
    run_instr(6'b001000, 4);
    run_instr(6'b000100, 3);
    run_instr(6'b000101, 3);
    run_instr(6'b000010, 3);
    run_instr(6'b111111, 2);

    // reset while in MEMRD, then confirm one settling cycle before DECODE
    for (int i = 0; i < 3; i++) step(6'b100011, 1'b1);
    check_eq("in_memrd", 32'(state), 32'd3);
    do_reset();
    step(6'b100011, 1'b1);
    check_eq("post_reset_fetch", 32'(state), 32'd0);
    step(6'b100011, 1'b1);
    check_eq("post_reset_decode", 32'(state), 32'd1);

`ifdef MC_MEM_WAIT_EN
    begin
      int mw = 0;
      for (int i = 0; i < 20 && state != 4'd0; i++) step(6'h3f, 1'b1);
      step(6'b101011, 1'b1);
      step(6'b101011, 1'b1);
      step(6'b101011, 1'b1);
      if (MemWrite) mw++;
      for (int i = 0; i < 3; i++) begin
        step(6'b101011, 1'b0);
        if (MemWrite) mw++;
      end
      step(6'b101011, 1'b1);
      check_eq("sw_wait_memwrite_cycles", 32'(mw), 32'd4);
      check_eq("sw_wait_to_fetch", 32'(state), 32'd0);
    end
`endif

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 7)];
      if ($urandom_range(0, 59) == 0) do_reset();
      else step(op, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 No parameters; all encodings come from the shared package.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  IR[31:26]; sampled only in DECODE.
REQ-005 mem_ready  in  1  memory access complete this cycle.
REQ-006 IorD  out  1  memory address: 0=PC, 1=ALUOut.
REQ-007 MemRead  out  1  memory read strobe.
REQ-008 MemWrite  out  1  memory write strobe.
REQ-009 IRWrite  out  1  load instruction register.
REQ-010 MemtoReg  out  1  write-back data: 0=ALUOut, 1=MDR.
REQ-011 RegDst  out  1  destination register: 0=rt, 1=rd.
REQ-012 RegWrite  out  1  register-file write enable.
REQ-013 ALUSrcA  out  1  ALU A input: 0=PC, 1=rs.
REQ-014 ALUSrcB  out  2  ALU B input: 00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2.
REQ-015 AluOP  out  2  00=add, 01=sub, 10=funct-decoded.
REQ-016 PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-017 PCWrite  out  1  unconditional PC load.
REQ-018 PCWriteCond  out  1  PC load if zero (beq).
REQ-019 PCWriteCondNot  out  1  PC load if !zero (bne).
REQ-020 illegal_op  out  1  unsupported opcode detected.
REQ-021 state  out  4  current state code, for debug.

Function
REQ-022 Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, BNE=9, ADDIEX=10, ADDIWB=11, JUMP=12; codes 13-15 go to FETCH next cycle, with all outputs 0.
REQ-023 Transitions:
- FETCH->DECODE.
- DECODE by opcode: lw/sw (100011/101011)->MEMADR; R-type (000000)->EXEC; beq (000100)->BEQ; bne (000101)->BNE; addi (001000)->ADDIEX; j (000010)->JUMP; any other->FETCH.
- MEMADR->MEMRD (lw) or MEMWR (sw).
- MEMRD->MEMWB; EXEC->RWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, RWB, ADDIWB, BEQ, BNE, JUMP->FETCH.
REQ-024 Per-state outputs; every output not listed is 0:
- FETCH: MemRead, IRWrite, PCWrite=1; ALUSrcB=01.
- DECODE: ALUSrcB=11.
- MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
- MEMRD: MemRead=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1.
- MEMWR: MemWrite=1, IorD=1.
- EXEC: ALUSrcA=1, AluOP=10.
- RWB: RegWrite=1, RegDst=1.
- BEQ/BNE: ALUSrcA=1, AluOP=01, PCSource=01, plus PCWriteCond (BEQ) or PCWriteCondNot (BNE).
- ADDIWB: RegWrite=1.
- JUMP: PCSource=10, PCWrite=1.
REQ-025 illegal_op is 1 for exactly the single DECODE cycle in which the opcode is unsupported; it is 0 in all other cycles.
REQ-026 Cycles from FETCH entry back to FETCH, with mem_ready held at 1: lw 5; sw, R-type, addi 4; beq, bne, j 3.
REQ-027 A change of opcode outside DECODE has no effect on state or outputs.

Reset
REQ-028 While reset is high, state=FETCH, all control outputs and illegal_op are 0, and state=0; the FSM asynchronously aborts any in-flight instruction.
REQ-029 On the first rising clk edge after reset deasserts, FETCH outputs apply; the first transition occurs on the following edge.

Configuration
REQ-030 With MC_MEM_WAIT_EN defined:
- FETCH, MEMRD and MEMWR hold state while mem_ready=0, keeping MemRead/MemWrite/IorD asserted.
- In FETCH, IRWrite and PCWrite equal mem_ready.
- Reset during a wait returns to FETCH.
REQ-031 Without MC_MEM_WAIT_EN, mem_ready is ignored and every state lasts one cycle.

Structure
REQ-032 A package mips_ctrl_pkg holds the opcode constants, the state enum/codes, and the AluOP, ALUSrcB and PCSource encodings.
REQ-033 One combinational sub-module, mc_output_decode, maps state (and mem_ready) to the control outputs; the top module holds the state register and next-state logic.

Verification
REQ-034 Reset mid-MEMRD, then release -> state=0 immediately; first DECODE two edges after release.
REQ-035 opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-036 opcode=000101 -> states 0,1,9,0; PCWriteCondNot=1 and PCSource=01 in state 9; PCWriteCond=0 throughout.
REQ-037 opcode=111111 -> states 0,1,0; illegal_op=1 for exactly one cycle; RegWrite and MemWrite stay 0.
REQ-038 MC_MEM_WAIT_EN defined, sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-039 opcode=000010 -> states 0,1,12,0; PCWrite=1 and PCSource=10 in state 12.
